// File: rtl/uart_tx_byte.sv
// uart_tx_byte: UART byte transmitter.
// Takes one byte per valid/ready handshake and sends it on oTxBit as a frame:
// a start bit, 8 data bits LSB first, an optional odd or even parity bit, then
// STOP_BITS stop bits. Bit timing comes from a 24-bit phase accumulator, so
// the clock/baud ratio does not have to be an integer.
//
// Ports:
//   Clk          system clock, rising edge
//   Rst          asynchronous active-high reset
//   iTx_Val      iTx_Data holds a byte to send
//   iTx_Data     byte to send
//   iCheck_odd   append odd parity (latched at accept; wins over even)
//   iCheck_even  append even parity (latched at accept)
//   oTx_Rdy      idle, ready to accept a byte
//   oTx_Busy     a frame is in progress
//   oTx_Done     one-cycle pulse when the last stop bit ends
//   oTxBit       serial line, idles high
module uart_tx_byte #(
  parameter int unsigned BAUD_RATE = 2_000_000,
  parameter int unsigned SYS_FREQ  = 50_000_000,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       iTx_Val,
  input  logic [7:0] iTx_Data,
  input  logic       iCheck_odd,
  input  logic       iCheck_even,
  output logic       oTx_Rdy,
  output logic       oTx_Busy,
  output logic       oTx_Done,
  output logic       oTxBit
);

  // Phase increment per clock, rounded to nearest: BAUD_RATE * 2^24 / SYS_FREQ
  localparam logic [63:0] CtrlWide =
    ((64'(BAUD_RATE) << 24) + 64'(SYS_FREQ / 2)) / 64'(SYS_FREQ);
  localparam logic [23:0] CTRL = CtrlWide[23:0];

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state;
  logic [23:0] acc;
  logic [24:0] accSum;
  logic        tick;
  logic [7:0]  shiftReg;
  logic [2:0]  bitIdx;
  logic        parityEn;
  logic        parityBit;
  logic        stopCnt;
  logic        lastStop;

  // A bit boundary falls on the accumulator carry
  assign accSum   = {1'b0, acc} + {1'b0, CTRL};
  assign tick     = accSum[24];
  assign lastStop = (STOP_BITS == 1) || stopCnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      acc       <= '0;
      shiftReg  <= '0;
      bitIdx    <= '0;
      parityEn  <= 1'b0;
      parityBit <= 1'b0;
      stopCnt   <= 1'b0;
      oTxBit    <= 1'b1;
      oTx_Rdy   <= 1'b1;
      oTx_Busy  <= 1'b0;
      oTx_Done  <= 1'b0;
    end else begin
      acc      <= accSum[23:0];
      oTx_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (iTx_Val && oTx_Rdy) begin
            // Clearing acc phase-aligns every frame to its accept edge
            acc       <= '0;
            state     <= START;
            shiftReg  <= iTx_Data;
            parityEn  <= iCheck_odd | iCheck_even;
            parityBit <= iCheck_odd ? ~^iTx_Data : ^iTx_Data;
            bitIdx    <= '0;
            stopCnt   <= 1'b0;
            oTxBit    <= 1'b0;
            oTx_Rdy   <= 1'b0;
            oTx_Busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state    <= DATA;
            oTxBit   <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
          end
        end
        DATA: begin
          if (tick) begin
            if (bitIdx != 3'd7) begin
              bitIdx   <= bitIdx + 3'd1;
              oTxBit   <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
            end else if (parityEn) begin
              state  <= PARITY;
              oTxBit <= parityBit;
            end else begin
              state  <= STOP;
              oTxBit <= 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state  <= STOP;
            oTxBit <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (lastStop) begin
              state    <= IDLE;
              oTx_Done <= 1'b1;
              oTx_Rdy  <= 1'b1;
              oTx_Busy <= 1'b0;
            end else begin
              stopCnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
`timescale 1ns/1ps
module tb_uart_tx_byte;

  localparam int unsigned SYS    = 50_000_000;
  localparam int unsigned BAUD_A = 3_125_000;
  localparam int unsigned BAUD_B = 2_000_000;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       tVal = 1'b0;
  logic [7:0] tData = '0;
  logic       tOdd = 1'b0;
  logic       tEven = 1'b0;
  logic       rdyA, busyA, doneA, bitA;
  logic       rdyB, busyB, doneB, bitB;

  always #10 Clk = ~Clk;

  uart_tx_byte #(.BAUD_RATE(BAUD_A), .SYS_FREQ(SYS), .STOP_BITS(1)) dutA (
    .Clk(Clk), .Rst(Rst), .iTx_Val(tVal), .iTx_Data(tData),
    .iCheck_odd(tOdd), .iCheck_even(tEven),
    .oTx_Rdy(rdyA), .oTx_Busy(busyA), .oTx_Done(doneA), .oTxBit(bitA));

  uart_tx_byte #(.BAUD_RATE(BAUD_B), .SYS_FREQ(SYS), .STOP_BITS(1)) dutB (
    .Clk(Clk), .Rst(Rst), .iTx_Val(tVal), .iTx_Data(tData),
    .iCheck_odd(tOdd), .iCheck_even(tEven),
    .oTx_Rdy(rdyB), .oTx_Busy(busyB), .oTx_Done(doneB), .oTxBit(bitB));

  int errors = 0;
  int checks = 0;

  logic [7:0] fData[$];
  logic       fOdd[$];
  logic       fEven[$];
  int         doneLog[$];
  logic       lineLog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference timing: phase increment and the edge on which bit k ends,
  // counted in clock edges after the accept edge.
  function automatic longint ctrlOf(input int unsigned baud);
    return (longint'(baud) * 64'd16777216 + longint'(SYS / 2)) / longint'(SYS);
  endfunction

  function automatic int boundary(input int k, input longint ctrl);
    return int'((longint'(k) * 64'd16777216 + ctrl - 1) / ctrl);
  endfunction

  task automatic waitIdle();
    int w = 0;
    while (!(rdyA && rdyB) && w < 2000) begin
      @(negedge Clk);
      w++;
    end
    check("idle wait", {31'd0, rdyA && rdyB}, 1);
  endtask

  // Plays the frames queued in fData/fOdd/fEven on one DUT (sel=1 -> B) with
  // iTx_Val held high across frames, and compares every cycle against the model.
  task automatic play(input string name, input bit sel, input bit glitch);
    longint ctrl;
    int     nF, total, k, L, nb, firstBad;
    int     misLine, misRdy, misBusy, misDone;
    int     accAt[];
    int     lenOf[];
    logic   bits[$];
    logic   eBit[], eRdy[], eDone[];
    logic   line, rdy, busy, done, par;
    int     nextF;
    ctrl = ctrlOf(sel ? BAUD_B : BAUD_A);
    nF = fData.size();
    accAt = new[nF];
    lenOf = new[nF];
    for (int f = 0; f < nF; f++) begin
      nb = 10 + ((fOdd[f] || fEven[f]) ? 1 : 0);
      lenOf[f] = boundary(nb, ctrl);
      accAt[f] = (f == 0) ? 0 : accAt[f-1] + lenOf[f-1] + 1;
    end
    total = accAt[nF-1] + lenOf[nF-1] + 4;
    eBit = new[total];
    eRdy = new[total];
    eDone = new[total];
    for (int n = 0; n < total; n++) begin
      eBit[n] = 1'b1; eRdy[n] = 1'b1; eDone[n] = 1'b0;
    end
    for (int f = 0; f < nF; f++) begin
      bits.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(fData[f][i]);
      par = ($countones(fData[f]) % 2) == 1;
      if (fOdd[f]) bits.push_back(!par);
      else if (fEven[f]) bits.push_back(par);
      bits.push_back(1'b1);
      k = 0;
      for (int n = 0; n < lenOf[f]; n++) begin
        while (k + 1 < bits.size() && boundary(k + 1, ctrl) <= n) k++;
        eBit[accAt[f] + n] = bits[k];
        eRdy[accAt[f] + n] = 1'b0;
      end
      eDone[accAt[f] + lenOf[f]] = 1'b1;
    end

    waitIdle();
    doneLog.delete();
    lineLog.delete();
    misLine = 0; misRdy = 0; misBusy = 0; misDone = 0; firstBad = -1;
    tVal = 1'b1; tData = fData[0]; tOdd = fOdd[0]; tEven = fEven[0];
    nextF = 1;
    for (int n = 0; n < total; n++) begin
      @(posedge Clk);
      @(negedge Clk);
      line = sel ? bitB : bitA;
      rdy  = sel ? rdyB : rdyA;
      busy = sel ? busyB : busyA;
      done = sel ? doneB : doneA;
      lineLog.push_back(line);
      if (done === 1'b1) doneLog.push_back(n);
      if (line !== eBit[n]) begin misLine++; if (firstBad < 0) firstBad = n; end
      if (rdy !== eRdy[n]) begin misRdy++; if (firstBad < 0) firstBad = n; end
      if (busy !== !eRdy[n]) begin misBusy++; if (firstBad < 0) firstBad = n; end
      if (done !== eDone[n]) begin misDone++; if (firstBad < 0) firstBad = n; end
      if (nextF < nF && n == accAt[nextF-1]) begin
        tData = fData[nextF]; tOdd = fOdd[nextF]; tEven = fEven[nextF];
        nextF++;
      end else if (n == accAt[nF-1]) begin
        tVal = 1'b0; tData = 8'hEE; tOdd = !tOdd; tEven = !tEven;
      end
      if (glitch && n == 50) begin tVal = 1'b1; tData = 8'hEE; end
      if (glitch && n == 60) tVal = 1'b0;
    end
    check($sformatf("%s line (first bad cycle %0d)", name, firstBad), misLine, 0);
    check($sformatf("%s rdy (first bad cycle %0d)", name, firstBad), misRdy, 0);
    check($sformatf("%s busy (first bad cycle %0d)", name, firstBad), misBusy, 0);
    check($sformatf("%s done (first bad cycle %0d)", name, firstBad), misDone, 0);
    check($sformatf("%s done count", name), doneLog.size(), nF);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       odd;
    logic       even;
    logic       hasPar;
    logic       parBit;
    int         len;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int   runLen, badLen, drift, dn, gap;
    logic [7:0] rx;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 160};
    tbl[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 176};
    tbl[2] = '{8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 176};
    tbl[3] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 176};
    tbl[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 160};
    tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 176};
    tbl[6] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 176};
    tbl[7] = '{8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 176};

    // Reset values, during and after reset
    repeat (3) @(negedge Clk);
    check("reset A line", bitA, 1);
    check("reset A rdy", rdyA, 1);
    check("reset A busy", busyA, 0);
    check("reset A done", doneA, 0);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    check("post-reset A line", bitA, 1);
    check("post-reset A rdy", rdyA, 1);
    check("post-reset B line", bitB, 1);
    check("post-reset B busy", busyB, 0);

    // Directed table on the 16 cycles/bit instance
    for (int v = 0; v < 8; v++) begin
      fData = {tbl[v].data}; fOdd = {tbl[v].odd}; fEven = {tbl[v].even};
      play($sformatf("vec%0d", v), 1'b0, 1'b0);
      rx = '0;
      for (int i = 0; i < 8; i++) rx[i] = lineLog[16 * (i + 1) + 8];
      check($sformatf("vec%0d data bits", v), rx, tbl[v].data);
      check($sformatf("vec%0d start bit", v), lineLog[8], 0);
      if (tbl[v].hasPar) check($sformatf("vec%0d parity bit", v), lineLog[152], tbl[v].parBit);
      check($sformatf("vec%0d stop bit", v), lineLog[16 * (tbl[v].hasPar ? 10 : 9) + 8], 1);
      if (doneLog.size() > 0) check($sformatf("vec%0d frame length", v), doneLog[0], tbl[v].len);
    end

    // Back-to-back 0x55 then 0xFF with iTx_Val held high
    fData = {8'h55, 8'hFF}; fOdd = {1'b0, 1'b0}; fEven = {1'b0, 1'b0};
    play("b2b", 1'b0, 1'b0);
    runLen = 0;
    for (int i = 160; i >= 0 && lineLog[i] === 1'b1; i--) runLen++;
    check("b2b stop bit length", runLen, 17);
    check("b2b frame2 start", lineLog[161], 0);
    if (doneLog.size() == 2) check("b2b done spacing", doneLog[1] - doneLog[0], 161);

    // Mid-frame data change and a second request while busy are ignored
    fData = {8'h12}; fOdd = {1'b0}; fEven = {1'b0};
    play("stability", 1'b0, 1'b1);
    rx = '0;
    for (int i = 0; i < 8; i++) rx[i] = lineLog[16 * (i + 1) + 8];
    check("stability data", rx, 8'h12);
    check("stability single done", doneLog.size(), 1);

    // Reset 50 cycles into a frame
    waitIdle();
    tVal = 1'b1; tData = 8'hC3; tOdd = 1'b1; tEven = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    tVal = 1'b0;
    repeat (50) @(negedge Clk);
    check("pre-abort busy", busyA, 1);
    check("pre-abort line", bitA, 0);
    #3 Rst = 1'b1;
    #1;
    check("abort line async", bitA, 1);
    check("abort rdy", rdyA, 1);
    check("abort busy", busyA, 0);
    dn = 0;
    repeat (3) begin @(negedge Clk); if (doneA) dn++; end
    Rst = 1'b0;
    repeat (200) begin @(negedge Clk); if (doneA) dn++; end
    check("abort no done", dn, 0);
    fData = {8'hC3}; fOdd = {1'b1}; fEven = {1'b0};
    play("after abort", 1'b0, 1'b0);

    // Randomized frames on either instance
    for (int r = 0; r < 16; r++) begin
      int nF;
      fData.delete(); fOdd.delete(); fEven.delete();
      nF = $urandom_range(1, 3);
      for (int f = 0; f < nF; f++) begin
        fData.push_back(8'($urandom_range(0, 255)));
        fOdd.push_back(1'($urandom_range(0, 1)));
        fEven.push_back(1'($urandom_range(0, 1)));
      end
      play($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Rate check at 2 Mbps: 100 consecutive frames of 0x00
    fData.delete(); fOdd.delete(); fEven.delete();
    for (int f = 0; f < 100; f++) begin
      fData.push_back(8'h00); fOdd.push_back(1'b0); fEven.push_back(1'b0);
    end
    play("rate", 1'b1, 1'b0);
    badLen = 0;
    for (int f = 0; f < doneLog.size(); f++) begin
      gap = (f == 0) ? doneLog[0] : doneLog[f] - doneLog[f-1] - 1;
      if (gap < 249 || gap > 251) badLen++;
    end
    check("rate frames outside 250+-1", badLen, 0);
    if (doneLog.size() == 100) begin
      drift = doneLog[99] - (100 * 10 * int'(SYS / BAUD_B) + 99);
      if (drift < 0) drift = -drift;
      check("rate drift under 1 bit", {31'd0, drift < int'(SYS / BAUD_B)}, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
